// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: aligns byte/half/word accesses onto a 32-bit word memory
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_we, req_size,            store/load, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_unsigned, req_addr,      zero/sign extension, byte address,
//   req_wdata                    right-justified store data
//   resp_valid, resp_rdata,      one-cycle completion pulse, load result,
//   resp_err                     illegal size or rejected misalignment
//   mem_addr, mem_read,          word-aligned memory address, read enable,
//   mem_wdata, mem_byte_en,      lane-aligned store data, per-lane write enable,
//   mem_rdata                    combinational read data
module lsu #(
  parameter int unsigned MISALIGN_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        err_q, err_d;

  // Size mask shifted by the byte offset into an 8-lane window spanning two words.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] sm;
    case (size)
      2'b00:   sm = 4'b0001;
      2'b01:   sm = 4'b0011;
      2'b10:   sm = 4'b1111;
      default: sm = 4'b0000;
    endcase
    return {4'b0000, sm} << off;
  endfunction

  function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    m = lane_mask(size, off);
    return |m[7:4];
  endfunction

  logic [7:0]  cur_mask;
  logic        cur_cross;
  logic        req_bad;
  logic [31:0] acc0_addr;
  logic [63:0] wide_wdata;
  logic [31:0] rd_word;
  logic [31:0] ld_result;

  assign cur_mask   = lane_mask(size_q, addr_q[1:0]);
  assign cur_cross  = |cur_mask[7:4];
  assign req_bad    = (req_size == 2'b11) ||
                      (crosses(req_size, req_addr[1:0]) && (MISALIGN_EN == 0));
  assign acc0_addr  = {addr_q[31:2], 2'b00};
  assign wide_wdata = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  // Bytes of interest start at the low end after shifting the two captured words down.
  assign rd_word    = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

  always_comb begin
    ld_result = rd_word;
    case (size_q)
      2'b00:   ld_result = uns_q ? {24'b0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
      2'b01:   ld_result = uns_q ? {16'b0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default: ld_result = rd_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = 32'b0;
    mem_addr    = 32'b0;
    mem_read    = 1'b0;
    mem_wdata   = 32'b0;
    mem_byte_en = 4'b0000;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lo_d    = 32'b0;
          hi_d    = 32'b0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_ACC0;
        end
      end
      S_ACC0: begin
        mem_addr    = acc0_addr;
        mem_read    = ~we_q;
        mem_wdata   = wide_wdata[31:0];
        mem_byte_en = we_q ? cur_mask[3:0] : 4'b0000;
        if (!we_q) lo_d = mem_rdata;
        state_d = cur_cross ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        mem_addr    = acc0_addr + 32'd4;
        mem_read    = ~we_q;
        mem_wdata   = wide_wdata[63:32];
        mem_byte_en = we_q ? cur_mask[7:4] : 4'b0000;
        if (!we_q) hi_d = mem_rdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'b0 : ld_result;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

endmodule
